// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data-memory stage.
// DM has fixed priority, IF is protected by a starvation limit, and busy states are watchdog-bounded.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_err
);

   localparam int unsigned     SC_W    = $clog2(STARVE_MAX + 1);
   localparam int unsigned     WD_W    = $clog2(TIMEOUT);
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_DM_BUSY = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SC_W-1:0]   r_starve_cnt;
   logic [WD_W-1:0]   r_wd_cnt;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_valid;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_dm_valid;
   logic [DATA_W-1:0] r_dm_rdata;
   logic              r_mem_err;

   logic w_grant_dm;
   logic w_grant_if;
   logic w_done;
   logic w_abort;
   logic w_if_deliver;
   logic w_dm_deliver;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_dm   = 1'b0;
      w_grant_if   = 1'b0;
      w_done       = 1'b0;
      w_abort      = 1'b0;
      w_if_deliver = 1'b0;
      w_dm_deliver = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dm_req && (!if_req || (r_starve_cnt < SC_MAX))) begin
               w_grant_dm  = 1'b1;
               w_state_nxt = ST_DM_BUSY;
            end else if (if_req) begin
               w_grant_if  = 1'b1;
               w_state_nxt = ST_IF_BUSY;
            end
         end
         ST_IF_BUSY, ST_DM_BUSY: begin
            // ack is tested first so an ack on the watchdog's last cycle still completes
            if (mem_ack) begin
               w_done       = 1'b1;
               w_state_nxt  = ST_IDLE;
               w_if_deliver = (r_state == ST_IF_BUSY) && if_req && (if_addr == r_mem_addr);
               w_dm_deliver = (r_state == ST_DM_BUSY) && dm_req;
            end else if (r_wd_cnt == WD_LAST) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve_cnt <= '0;
         r_wd_cnt     <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_if_valid   <= 1'b0;
         r_if_rdata   <= '0;
         r_dm_valid   <= 1'b0;
         r_dm_rdata   <= '0;
         r_mem_err    <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_dm_valid <= 1'b0;

         if (w_grant_dm) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_wd_cnt    <= '0;
            if (if_req && (r_starve_cnt < SC_MAX)) begin
               r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end
         end else if (w_grant_if) begin
            r_mem_en     <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_wd_cnt     <= '0;
            r_starve_cnt <= '0;
         end else if (w_done || w_abort) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
         end else if (r_state != ST_IDLE) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
         end

         if (w_abort) begin
            r_mem_err <= 1'b1;
         end

         if (w_if_deliver) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= mem_rdata;
         end

         if (w_dm_deliver) begin
            r_dm_valid <= 1'b1;
            if (!r_mem_we) begin
               r_dm_rdata <= mem_rdata;
            end
         end
      end
   end

   assign if_valid  = r_if_valid;
   assign if_rdata  = r_if_rdata;
   assign dm_valid  = r_dm_valid;
   assign dm_rdata  = r_dm_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_err   = r_mem_err;
   assign stall_if  = if_req & ~r_if_valid;
   assign stall_mem = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random
// requester/memory traffic, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned TIMEOUT    = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_valid;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STARVE_MAX(STARVE_MAX),
      .TIMEOUT   (TIMEOUT)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_valid (if_valid),
      .if_rdata (if_rdata),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_valid (dm_valid),
      .dm_rdata (dm_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .stall_if (stall_if),
      .stall_mem(stall_mem),
      .mem_err  (mem_err)
   );

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   // reference model: owner 0 = memory free, 1 = fetch transaction, 2 = data transaction
   int          m_owner;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_we;
   int unsigned m_starve;
   logic        m_err;
   int unsigned cyc;
   int unsigned m_grant_cyc;
   bit          m_new_grant;
   logic        e_if_valid;
   logic        e_dm_valid;
   logic [31:0] e_if_rdata;
   logic [31:0] e_dm_rdata;

   // memory responder knobs: delay_mode -2 random, -1 never ack, >=0 fixed busy-cycle index
   int          busy_idx;
   int          ack_delay;
   int          delay_mode;
   bit          spurious_ack;
   bit          rdata_fixed;
   logic [31:0] rdata_val;
   logic [31:0] grant_addr_q[$];

   function automatic logic [31:0] b2w(input logic b);
      return {31'd0, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
   endfunction

   function automatic int pick_delay();
      if (delay_mode >= -1) return delay_mode;
      case ($urandom_range(0, 9))
         0:       return 15;
         1:       return -1;
         default: return int'($urandom_range(0, 4));
      endcase
   endfunction

   task automatic model_reset();
      m_owner    = 0;
      m_starve   = 0;
      m_err      = 1'b0;
      e_if_valid = 1'b0;
      e_dm_valid = 1'b0;
      e_if_rdata = '0;
      e_dm_rdata = '0;
      busy_idx   = 0;
   endtask

   task automatic model_edge();
      cyc++;
      e_if_valid  = 1'b0;
      e_dm_valid  = 1'b0;
      m_new_grant = 1'b0;
      if (m_owner == 0) begin
         if (dm_req && (!if_req || m_starve < STARVE_MAX)) begin
            m_owner = 2; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
            m_new_grant = 1'b1;
            if (if_req && m_starve < STARVE_MAX) m_starve++;
         end else if (if_req) begin
            m_owner = 1; m_addr = if_addr; m_we = 1'b0;
            m_new_grant = 1'b1;
            m_starve = 0;
         end
         if (m_new_grant) begin
            m_grant_cyc = cyc;
            busy_idx    = 0;
            ack_delay   = pick_delay();
         end
      end else if (mem_ack) begin
         if (m_owner == 1 && if_req && if_addr == m_addr) begin
            e_if_valid = 1'b1;
            e_if_rdata = mem_rdata;
         end
         if (m_owner == 2 && dm_req) begin
            e_dm_valid = 1'b1;
            if (!m_we) e_dm_rdata = mem_rdata;
         end
         m_owner = 0;
      end else if (cyc - m_grant_cyc == TIMEOUT) begin
         m_owner = 0;
         m_err   = 1'b1;
      end else begin
         busy_idx++;
      end
   endtask

   task automatic drive_mem();
      mem_rdata = rdata_fixed ? rdata_val : $urandom;
      if (m_owner != 0) mem_ack = (busy_idx == ack_delay);
      else              mem_ack = spurious_ack && ($urandom_range(0, 9) == 0);
   endtask

   task automatic check_regs();
      check("mem_en", b2w(mem_en), b2w(m_owner != 0));
      if (m_owner != 0) begin
         check("mem_addr", mem_addr, m_addr);
         check("mem_we", b2w(mem_we), b2w(m_we));
         if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      check("if_valid", b2w(if_valid), b2w(e_if_valid));
      check("dm_valid", b2w(dm_valid), b2w(e_dm_valid));
      check("if_rdata", if_rdata, e_if_rdata);
      check("dm_rdata", dm_rdata, e_dm_rdata);
      check("mem_err", b2w(mem_err), b2w(m_err));
   endtask

   // one clock: called and returns at a falling edge with requester inputs already set
   task automatic tick();
      drive_mem();
      #1;
      check("stall_if", b2w(stall_if), b2w(if_req & ~e_if_valid));
      check("stall_mem", b2w(stall_mem), b2w(dm_req & ~e_dm_valid));
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
      if (m_new_grant) grant_addr_q.push_back(mem_addr);
      @(negedge clk);
   endtask

   task automatic go_idle();
      if_req = 1'b0;
      dm_req = 1'b0;
      for (int i = 0; i < 40 && m_owner != 0; i++) tick();
      tick();
   endtask

   task automatic drive_random();
      int unsigned r;
      if (!if_req) begin
         if ($urandom_range(0, 9) < 6) begin
            if_req  = 1'b1;
            if_addr = rand_addr();
         end
      end else if (e_if_valid) begin
         if ($urandom_range(0, 9) < 7) if_addr = if_addr + 32'd4;
         else                          if_req  = 1'b0;
      end else begin
         r = $urandom_range(0, 99);
         if (r < 3)      if_addr = rand_addr();
         else if (r < 5) if_req  = 1'b0;
      end
      if (!dm_req || e_dm_valid) begin
         if ($urandom_range(0, 9) < 4) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = rand_addr();
            dm_wdata = $urandom;
         end else begin
            dm_req = 1'b0;
         end
      end else if ($urandom_range(0, 99) < 3) begin
         dm_req = 1'b0;
      end
   endtask

   initial begin
      int unsigned cnt;
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      cyc = 0; delay_mode = 0; spurious_ack = 1'b0; rdata_fixed = 1'b0; rdata_val = '0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0; m_grant_cyc = 0; ack_delay = 0; m_new_grant = 1'b0;
      model_reset();

      #3 reset = 1'b0;
      #1;
      check("rst mem_en", b2w(mem_en), 32'd0);
      check("rst mem_we", b2w(mem_we), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst mem_wdata", mem_wdata, 32'd0);
      check("rst if_valid", b2w(if_valid), 32'd0);
      check("rst dm_valid", b2w(dm_valid), 32'd0);
      check("rst mem_err", b2w(mem_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // fetch alone, ack in the fourth busy cycle
      delay_mode = 3; rdata_fixed = 1'b1; rdata_val = 32'h8C01_0004;
      if_req = 1'b1; if_addr = 32'h40;
      tick();
      check("T1 mem_addr", mem_addr, 32'h40);
      check("T1 mem_we", b2w(mem_we), 32'd0);
      for (int i = 0; i < 20 && !e_if_valid; i++) tick();
      check("T1 if_valid", b2w(if_valid), 32'd1);
      check("T1 if_rdata", if_rdata, 32'h8C01_0004);
      check("T1 stall_if", b2w(stall_if), 32'd0);
      rdata_fixed = 1'b0;
      go_idle();

      // simultaneous requests: store first, then fetch
      grant_addr_q.delete();
      delay_mode = 1;
      if_req = 1'b1; if_addr = 32'h44;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
      tick();
      check("T2 mem_we", b2w(mem_we), 32'd1);
      check("T2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      for (int i = 0; i < 20 && !e_dm_valid; i++) tick();
      check("T2 dm_valid", b2w(dm_valid), 32'd1);
      dm_req = 1'b0;
      for (int i = 0; i < 20 && !e_if_valid; i++) tick();
      check("T2 if_valid", b2w(if_valid), 32'd1);
      check("T2 ngrants", 32'(grant_addr_q.size()), 32'd2);
      if (grant_addr_q.size() >= 2) begin
         check("T2 grant0", grant_addr_q[0], 32'h10);
         check("T2 grant1", grant_addr_q[1], 32'h44);
      end
      go_idle();

      // both held: STARVE_MAX data grants, then one fetch grant
      grant_addr_q.delete();
      delay_mode = 0;
      if_req = 1'b1; if_addr = 32'h80;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
      for (int i = 0; i < 16; i++) tick();
      check("T3 enough grants", b2w(grant_addr_q.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i < grant_addr_q.size())
            check($sformatf("T3 grant%0d", i), grant_addr_q[i], (i < 4) ? 32'h20 : 32'h80);
      end
      go_idle();

      // fetch redirected while busy
      grant_addr_q.delete();
      delay_mode = 3;
      if_req = 1'b1; if_addr = 32'h40;
      tick();
      tick();
      if_addr = 32'h80;
      for (int i = 0; i < 30 && !e_if_valid; i++) tick();
      check("T4 if_valid", b2w(if_valid), 32'd1);
      check("T4 ngrants", 32'(grant_addr_q.size()), 32'd2);
      if (grant_addr_q.size() >= 2) begin
         check("T4 grant0", grant_addr_q[0], 32'h40);
         check("T4 grant1", grant_addr_q[1], 32'h80);
      end
      go_idle();

      // load never acked: watchdog abort, sticky error, retry succeeds
      delay_mode = -1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (mem_en) cnt++;
         if (m_err) break;
      end
      check("T5 busy cycles", cnt, TIMEOUT);
      check("T5 mem_err", b2w(mem_err), 32'd1);
      delay_mode = 1;
      for (int i = 0; i < 20 && !e_dm_valid; i++) tick();
      check("T5 dm_valid", b2w(dm_valid), 32'd1);
      check("T5 mem_err sticky", b2w(mem_err), 32'd1);
      go_idle();

      // asynchronous reset in the middle of a data access
      delay_mode = -1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h50; dm_wdata = 32'h1234_5678;
      tick(); tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("T6 mem_en", b2w(mem_en), 32'd0);
      check("T6 dm_valid", b2w(dm_valid), 32'd0);
      check("T6 mem_err", b2w(mem_err), 32'd0);
      check("T6 mem_addr", mem_addr, 32'd0);
      model_reset();
      if_req = 1'b0; dm_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      delay_mode = 2;
      if_req = 1'b1; if_addr = 32'h100;
      for (int i = 0; i < 20 && !e_if_valid; i++) tick();
      check("T6 if_valid", b2w(if_valid), 32'd1);
      go_idle();

      // random traffic with random ack latency, timeouts and stray acks
      delay_mode = -2;
      spurious_ack = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
